// File: rtl/sync_fifo_bypass.sv
// sync_fifo_bypass: single-clock show-ahead FIFO with read-when-empty bypass
// and write-when-full-with-read support. Flags and count are registered.
// Optional sticky error flags (overflow_err, underflow_err) are compiled in
// when the macro FIFO_ERR_FLAG_EN is defined.
module sync_fifo_bypass #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned AF_THRESH = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     write_en,
   input  logic [DATA_W-1:0]        write_data,
   input  logic                     read_en,
   output logic [DATA_W-1:0]        read_data,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic [$clog2(DEPTH):0]   count
`ifdef FIFO_ERR_FLAG_EN
   ,
   output logic                     overflow_err,
   output logic                     underflow_err
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              wr_acc;
   logic              rd_acc;
   logic              bypass;
   logic              do_wr;
   logic              do_rd;
   logic [CW-1:0]     count_next;

   // Accept decisions and the resulting occupancy for this edge.
   // A bypassed word never touches storage, so it is stripped out of both
   // the write and read actions before the count is updated.
   always_comb begin
      wr_acc     = write_en && (!full || read_en);
      rd_acc     = read_en && (!empty || write_en);
      bypass     = wr_acc && rd_acc && empty;
      do_wr      = wr_acc && !bypass;
      do_rd      = rd_acc && !bypass;
      count_next = count;
      if (do_wr && !do_rd) begin
         count_next = count + CW'(1);
      end else if (do_rd && !do_wr) begin
         count_next = count - CW'(1);
      end
   end

   // Show-ahead head word, bypassed write word when empty, zero otherwise.
   always_comb begin
      read_data = '0;
      if (rst) begin
         read_data = '0;
      end else if (empty) begin
         if (write_en) begin
            read_data = write_data;
         end
      end else begin
         read_data = mem[rd_ptr];
      end
   end

   // Storage array write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= write_data;
      end
   end

   // Pointers, count and registered flags derived from the next count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         empty       <= 1'b1;
         full        <= 1'b0;
         almost_full <= 1'b0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count       <= count_next;
         empty       <= (count_next == '0);
         full        <= (count_next == CW'(DEPTH));
         almost_full <= (count_next >= CW'(AF_THRESH));
      end
   end

`ifdef FIFO_ERR_FLAG_EN
   // Sticky error flags for requests that can never be accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         if (write_en && full && !read_en) begin
            overflow_err <= 1'b1;
         end
         if (read_en && empty && !write_en) begin
            underflow_err <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo_bypass.sv
// Testbench for sync_fifo_bypass: queue-based reference model checked every
// cycle, plus directed vectors with literal expectations.
module tb_sync_fifo_bypass;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        write_en = 1'b0;
   logic        read_en = 1'b0;
   logic [31:0] write_data = '0;
   logic [31:0] read_data;
   logic        full;
   logic        empty;
   logic        almost_full;
   logic [3:0]  count;
`ifdef FIFO_ERR_FLAG_EN
   logic        overflow_err;
   logic        underflow_err;
`endif

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;
   bit          cmp_en = 1'b0;

   logic [31:0] q[$];
   bit          m_ovf = 1'b0;
   bit          m_unf = 1'b0;

   sync_fifo_bypass #(
      .DATA_W(32),
      .DEPTH(8),
      .AF_THRESH(6)
   ) dut (
      .clk(clk),
      .rst(rst),
      .write_en(write_en),
      .write_data(write_data),
      .read_en(read_en),
      .read_data(read_data),
      .full(full),
      .empty(empty),
      .almost_full(almost_full),
      .count(count)
`ifdef FIFO_ERR_FLAG_EN
      ,
      .overflow_err(overflow_err),
      .underflow_err(underflow_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue updated from the accept rules.
   initial begin
      bit wr;
      bit rd;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
         end else begin
            wr = write_en && (q.size() < 8 || read_en);
            rd = read_en && (q.size() > 0 || write_en);
            if (write_en && q.size() == 8 && !read_en) m_ovf = 1'b1;
            if (read_en && q.size() == 0 && !write_en) m_unf = 1'b1;
            if (!(q.size() == 0 && wr && rd)) begin
               if (rd) void'(q.pop_front());
               if (wr) q.push_back(write_data);
            end
         end
      end
   end

   // Per-cycle compare, one time unit before each rising edge.
   initial begin
      logic [31:0] exp_rd;
      forever begin
         @(negedge clk);
         #4;
         if (cmp_en) begin
            if (rst) exp_rd = '0;
            else if (q.size() == 0) exp_rd = write_en ? write_data : 32'h0;
            else exp_rd = q[0];
            chk("m_read_data", read_data, exp_rd);
            chk("m_count", 32'(count), 32'(q.size()));
            chk("m_empty", 32'(empty), 32'(q.size() == 0));
            chk("m_full", 32'(full), 32'(q.size() == 8));
            chk("m_almost_full", 32'(almost_full), 32'(q.size() >= 6));
`ifdef FIFO_ERR_FLAG_EN
            chk("m_overflow_err", 32'(overflow_err), 32'(m_ovf));
            chk("m_underflow_err", 32'(underflow_err), 32'(m_unf));
`endif
         end
      end
   end

   task automatic drive(input bit we, input logic [31:0] wd, input bit re);
      @(negedge clk);
      write_en   = we;
      write_data = wd;
      read_en    = re;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #1 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      cmp_en = 1'b1;
      #1;
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_empty", 32'(empty), 32'd1);
      chk("reset_full", 32'(full), 32'd0);
      chk("reset_read_data", read_data, 32'd0);

      // Fill 0x1..0x8, then a dropped 9th write.
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 32'(i), 1'b0);
         #1;
         chk("fill_count", 32'(count), 32'(i - 1));
         chk("fill_almost_full", 32'(almost_full), 32'(i - 1 >= 6));
      end
      drive(1'b1, 32'h9, 1'b0);
      #1;
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count8", 32'(count), 32'd8);
      drive(1'b0, 32'h0, 1'b0);
      #1;
      chk("overflow_count", 32'(count), 32'd8);
`ifdef FIFO_ERR_FLAG_EN
      chk("overflow_err", 32'(overflow_err), 32'd1);
`endif

      // Drain in order, then a 9th read on empty.
      for (int i = 1; i <= 8; i++) begin
         drive(1'b0, 32'h0, 1'b1);
         #1;
         chk("drain_data", read_data, 32'(i));
      end
      drive(1'b0, 32'h0, 1'b1);
      #1;
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_count", 32'(count), 32'd0);
      drive(1'b0, 32'h0, 1'b0);
      #1;
      chk("underflow_count", 32'(count), 32'd0);
`ifdef FIFO_ERR_FLAG_EN
      chk("underflow_err", 32'(underflow_err), 32'd1);
`endif

      // Bypass on empty.
      drive(1'b1, 32'hDEADBEEF, 1'b1);
      #1;
      chk("bypass_data", read_data, 32'hDEADBEEF);
      drive(1'b0, 32'h0, 1'b0);
      #1;
      chk("bypass_empty", 32'(empty), 32'd1);
      chk("bypass_count", 32'(count), 32'd0);

      // Simultaneous write and read while full.
      for (int i = 1; i <= 8; i++) drive(1'b1, 32'(i), 1'b0);
      drive(1'b1, 32'hA5A5A5A5, 1'b1);
      #1;
      chk("fullrw_head", read_data, 32'h1);
      drive(1'b0, 32'h0, 1'b0);
      #1;
      chk("fullrw_count", 32'(count), 32'd8);
      for (int i = 2; i <= 9; i++) begin
         drive(1'b0, 32'h0, 1'b1);
         #1;
         chk("fullrw_drain", read_data, (i == 9) ? 32'hA5A5A5A5 : 32'(i));
      end
      drive(1'b0, 32'h0, 1'b0);

      // Interleaved traffic across several pointer wraps.
      for (int i = 0; i < 40; i++) begin
         logic [31:0] d;
         d = $urandom;
         drive(i % 4 != 3, d, i % 3 != 0);
      end
      for (int i = 0; i < 10; i++) drive(1'b0, 32'h0, 1'b1);
      drive(1'b0, 32'h0, 1'b0);
      #1;
      chk("wrap_empty", 32'(empty), 32'd1);

      // Asynchronous reset in the middle of a cycle.
      for (int i = 0; i < 5; i++) drive(1'b1, 32'h100 + 32'(i), 1'b0);
      drive(1'b0, 32'h0, 1'b0);
      #1;
      chk("pre_rst_count", 32'(count), 32'd5);
      #2 rst = 1'b1;
      #1;
      chk("arst_empty", 32'(empty), 32'd1);
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_full", 32'(full), 32'd0);
      chk("arst_read_data", read_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 32'h77, 1'b0);
      drive(1'b0, 32'h0, 1'b1);
      #1;
      chk("post_rst_data", read_data, 32'h77);
      drive(1'b0, 32'h0, 1'b0);
      #1;
      chk("post_rst_empty", 32'(empty), 32'd1);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
